// File: rtl/dot_product_if.sv
// Operand/result bundle for vector-vector-to-scalar units.
// VECTOR_LEN travels with the interface so the unit sizes itself from it.
interface vec_vec_to_scalar #(
  parameter int VECTOR_LEN = 4
);
  logic [VECTOR_LEN-1:0][31:0] vec1;
  logic [VECTOR_LEN-1:0][31:0] vec2;
  logic [31:0]                 result;
  logic                        done;

  modport DUT (
    input  vec1,
    input  vec2,
    output result,
    output done
  );

  modport TB (
    output vec1,
    output vec2,
    input  result,
    input  done
  );
endinterface

// File: rtl/dot_product.sv
// Sequential binary32 dot product, one MAC per clock, flush-to-zero.
// Define DOT_PRODUCT_RNE_EN for round-to-nearest-even; default truncates.
module dot_product (
  input  logic          clk,
  input  logic          rst,
  vec_vec_to_scalar.DUT bus
);

  localparam int N  = bus.VECTOR_LEN;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

`ifdef DOT_PRODUCT_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  typedef enum logic {ACCUM, DONE} state_e;

  // m_in carries the hidden bit; e_in is the biased exponent
  function automatic logic [31:0] pack(
    input logic              s,
    input logic signed [9:0] e_in,
    input logic [23:0]       m_in,
    input logic              g,
    input logic              st
  );
    logic [24:0]       m;
    logic signed [9:0] e;
    logic [22:0]       frac;
    m    = {1'b0, m_in} + {24'd0, RNE & g & (st | m_in[0])};
    e    = m[24] ? e_in + 10'sd1 : e_in;
    frac = m[24] ? m[23:1] : m[22:0];
    if (e >= 10'sd255)
      pack = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      pack = {s, 31'd0};
    else
      pack = {s, e[7:0], frac};
  endfunction

  function automatic logic [31:0] fp_mul(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic              s, za, zb, ia, ib, na, nb;
    logic [47:0]       p;
    logic signed [9:0] e;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 8'd0);
    zb = (b[30:23] == 8'd0);
    ia = (&a[30:23]) && (a[22:0] == 23'd0);
    ib = (&b[30:23]) && (b[22:0] == 23'd0);
    na = (&a[30:23]) && (|a[22:0]);
    nb = (&b[30:23]) && (|b[22:0]);
    p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e  = $signed({2'b0, a[30:23]})
       + $signed({2'b0, b[30:23]})
       - 10'sd127;
    if (na | nb)
      fp_mul = QNAN;
    else if ((ia & zb) | (ib & za))
      fp_mul = QNAN;
    else if (ia | ib)
      fp_mul = {s, 8'hFF, 23'd0};
    else if (za | zb)
      fp_mul = {s, 31'd0};
    else if (p[47])
      fp_mul = pack(s, e + 10'sd1, p[47:24],
                    p[23], |p[22:0]);
    else
      fp_mul = pack(s, e, p[46:23],
                    p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic              za, zb, ia, ib, na, nb, swap, sub;
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [26:0]       mx, my, mask, sh, n;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] e;
    za   = (a[30:23] == 8'd0);
    zb   = (b[30:23] == 8'd0);
    ia   = (&a[30:23]) && (a[22:0] == 23'd0);
    ib   = (&b[30:23]) && (b[22:0] == 23'd0);
    na   = (&a[30:23]) && (|a[22:0]);
    nb   = (&b[30:23]) && (|b[22:0]);
    swap = (b[30:0] > a[30:0]);
    x    = swap ? b : a;
    y    = swap ? a : b;
    sub  = x[31] ^ y[31];
    d    = x[30:23] - y[30:23];
    mx   = {1'b1, x[22:0], 3'b000};
    my   = {1'b1, y[22:0], 3'b000};
    // bits shifted past the guard/round pair collapse into sticky
    mask = ~(27'h7FF_FFFF << d);
    sh   = (my >> d) | {26'd0, |(my & mask)};
    sum  = sub ? {1'b0, mx} - {1'b0, sh}
               : {1'b0, mx} + {1'b0, sh};
    lz   = 5'd0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = $signed({2'b0, x[30:23]}) + 10'sd1;
    end else begin
      n = sum[26:0] << lz;
      e = $signed({2'b0, x[30:23]})
        - $signed({5'd0, lz});
    end
    if (na | nb)
      fp_add = QNAN;
    else if (ia & ib & (a[31] ^ b[31]))
      fp_add = QNAN;
    else if (ia)
      fp_add = {a[31], 8'hFF, 23'd0};
    else if (ib)
      fp_add = {b[31], 8'hFF, 23'd0};
    else if (za & zb)
      fp_add = {a[31] & b[31], 31'd0};
    else if (za)
      fp_add = b;
    else if (zb)
      fp_add = a;
    else if (sum == 28'd0)
      fp_add = 32'd0;
    else
      fp_add = pack(x[31], e, n[26:3], n[2], |n[1:0]);
  endfunction

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   result_q, result_d;
  logic          done_q, done_d;
  logic [31:0]   mac;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = done_q;
    mac      = fp_add(acc_q, fp_mul(bus.vec1[idx_q], bus.vec2[idx_q]));
    unique case (state_q)
      ACCUM: begin
        acc_d = mac;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
          idx_d   = '0;
        end
      end
      DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACCUM;
      idx_q    <= '0;
      acc_q    <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_dot_product.sv
// Scoreboard bench for dot_product: random and directed vectors
// against a real-arithmetic reference rounded to binary32.
module tb_dot_product;

  localparam int N = 4;

`ifdef DOT_PRODUCT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef logic [N-1:0][31:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_vec_to_scalar #(.VECTOR_LEN(N)) bus ();

  dot_product dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always @(posedge clk) edge_cnt <= rst ? 0 : edge_cnt + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  function automatic real f2r(logic [31:0] f);
    logic [10:0] e11;
    if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
    e11 = {3'd0, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e11, f[22:0], 29'd0});
  endfunction

  // round an exactly-representable double to binary32
  function automatic logic [31:0] r2f(real x);
    logic [63:0] b;
    logic [24:0] m;
    logic [28:0] rest;
    int e;
    b = $realtobits(x);
    if (b[62:0] == 63'd0) return {b[63], 31'd0};
    e    = int'(b[62:52]) - 896;
    m    = {2'b01, b[51:29]};
    rest = b[28:0];
    if (RNE && rest[28] && ((rest[27:0] != 0) || m[0])) m = m + 1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {b[63], 8'hFF, 23'd0};
    if (e <= 0) return {b[63], 31'd0};
    return {b[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] model(vec_t a, vec_t b);
    logic [31:0] acc, p;
    acc = 32'd0;
    for (int i = 0; i < N; i++) begin
      p   = r2f(f2r(a[i]) * f2r(b[i]));
      acc = r2f(f2r(acc) + f2r(p));
    end
    return acc;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++)
      v[i] = {1'($urandom_range(1, 0)),
              8'($urandom_range(130, 124)),
              23'($urandom)};
    return v;
  endfunction

  task automatic run(string nm, vec_t a, vec_t b, logic [31:0] expv);
    bit got;
    @(negedge clk);
    bus.vec1 = a;
    bus.vec2 = b;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk({nm, " reset done"}, {31'd0, bus.done}, 32'd0);
    chk({nm, " reset result"}, bus.result, 32'd0);
    exp_q.push_back(expv);
    name_q.push_back(nm);
    rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.done;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: done still %b after 20 cycles", nm, bus.done);
      exp_q.delete();
      name_q.delete();
    end else begin
      @(negedge clk);
      bus.vec1 = rand_vec();
      bus.vec2 = rand_vec();
      repeat (3) @(negedge clk);
      chk({nm, " hold done"}, {31'd0, bus.done}, 32'd1);
      chk({nm, " hold result"}, bus.result, expv);
    end
  endtask

  // monitor: pops the scoreboard when done rises
  initial begin
    bit seen;
    logic [31:0] e;
    string nm;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (bus.done && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected done: result %h, nothing expected", bus.result);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          chk({nm, " result"}, bus.result, e);
          chk({nm, " latency"}, 32'(edge_cnt), 32'(N + 1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ONE  = 32'h3F80_0000;
  localparam logic [31:0] TWO  = 32'h4000_0000;
  localparam logic [31:0] HALF = 32'h3F00_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;

  initial begin
    vec_t a, b;
    bus.vec1 = '0;
    bus.vec2 = '0;

    run("ones", {ONE, ONE, ONE, ONE}, {ONE, ONE, ONE, TWO},
        32'h40A0_0000);
    run("signed", {32'hC080_0000, 32'h4040_0000, 32'hC000_0000, ONE},
        {ONE, ONE, ONE, ONE}, 32'hC000_0000);
    run("zeros", '0, '0, 32'h0000_0000);
    run("halves", {HALF, HALF, HALF, HALF}, {HALF, HALF, HALF, HALF}, ONE);
    run("round", {32'd0, 32'd0, 32'h3440_0000, ONE},
        {32'd0, 32'd0, ONE, ONE},
        RNE ? 32'h3F80_0002 : 32'h3F80_0001);
    run("inf_x_0", {32'd0, 32'd0, 32'd0, INF}, {32'd0, 32'd0, ONE, 32'd0},
        32'h7FC0_0000);
    run("overflow", {32'd0, 32'd0, 32'h7F00_0000, 32'h7F00_0000},
        {32'd0, 32'd0, TWO, TWO}, INF);

    // abort after one element, then a clean rerun
    @(negedge clk);
    bus.vec1 = {ONE, ONE, ONE, ONE};
    bus.vec2 = {ONE, ONE, ONE, TWO};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    chk("abort result", bus.result, 32'd0);
    run("rerun", {ONE, ONE, ONE, ONE}, {ONE, ONE, ONE, TWO},
        32'h40A0_0000);

    for (int t = 0; t < 40; t++) begin
      a = rand_vec();
      b = rand_vec();
      run($sformatf("rand%0d", t), a, b, model(a, b));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
